vector_writeback_arbiter: RTL and testbench

Shares the vector register file's single write path between the ALU and the load/store unit. Accepts one whole-vector write request at a time using round-robin arbitration, then writes the vector one element per cycle. Each write drives the active-low write enable of one element register, plus a shared data bus. Sits between the execute/memory stages and the bank of element registers that makes up the vector register file.

---
 rtl/vwb_pkg.sv | 14 +
 rtl/rr_arbiter2.sv | 36 +++
 rtl/vector_writeback_arbiter.sv | 112 +++++++++++
 tb/tb_vector_writeback_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vwb_pkg.sv
// Shared types for the vector writeback arbiter: FSM state and write-source encoding.
package vwb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } vwb_state_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } vwb_src_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick between ALU and load/store requests; the pointer
// remembers the last served source so a tie goes to the other one.
module rr_arbiter2
    import vwb_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     req_alu,
    input  logic     req_mem,
    input  logic     update,
    output logic     valid,
    output vwb_src_t pick
);

    vwb_src_t last;

    always_comb begin
        valid = req_alu | req_mem;
        pick  = SRC_ALU;
        if (req_alu && req_mem) begin
            pick = (last == SRC_MEM) ? SRC_ALU : SRC_MEM;
        end else if (req_mem) begin
            pick = SRC_MEM;
        end
    end

    // Pointer starts at MEM so the first tie after reset goes to the ALU.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= SRC_MEM;
        end else if (update && valid) begin
            last <= pick;
        end
    end

endmodule

// File: rtl/vector_writeback_arbiter.sv
// Owns the vector register file write path: accepts one whole-vector request
// from ALU or load/store unit, then writes it one element per cycle.
module vector_writeback_arbiter
    import vwb_pkg::*;
#(
    parameter int N     = 8,
    parameter int LANES = 4,
    parameter int REGS  = 8,
    parameter int RA_W  = $clog2(REGS)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ_ALU,
    input  logic [RA_W-1:0]       ADDR_ALU,
    input  logic [LANES*N-1:0]    DATA_ALU,
    input  logic                  REQ_MEM,
    input  logic [RA_W-1:0]       ADDR_MEM,
    input  logic [LANES*N-1:0]    DATA_MEM,
    output logic                  GNT_ALU,
    output logic                  GNT_MEM,
    output logic [REGS*LANES-1:0] WE_N,
    output logic [N-1:0]          WD,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  DONE_SRC
);

    localparam int               CNT_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(LANES - 1);

    vwb_state_t         state;
    vwb_state_t         state_next;
    vwb_src_t           src;
    vwb_src_t           pick;
    logic               pick_valid;
    logic [CNT_W-1:0]   k;
    logic [RA_W-1:0]    addr;
    logic [LANES*N-1:0] data;

    rr_arbiter2 u_arb (
        .clk     (CLK),
        .rst     (RST),
        .req_alu (REQ_ALU),
        .req_mem (REQ_MEM),
        .update  (state == IDLE),
        .valid   (pick_valid),
        .pick    (pick)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Requests are only looked at in IDLE, which forces a gap cycle between transfers.
    always_comb begin
        state_next = state;
        if (state == IDLE) begin
            if (pick_valid) begin
                state_next = WRITE;
            end
        end else if (k == LAST_K) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            k    <= '0;
            src  <= SRC_ALU;
            addr <= '0;
            data <= '0;
        end else if (state == IDLE) begin
            k <= '0;
            if (pick_valid) begin
                src  <= pick;
                addr <= (pick == SRC_MEM) ? ADDR_MEM : ADDR_ALU;
                data <= (pick == SRC_MEM) ? DATA_MEM : DATA_ALU;
            end
        end else begin
            k <= (k == LAST_K) ? '0 : k + 1'b1;
        end
    end

    assign BUSY     = (state == WRITE);
    assign GNT_ALU  = BUSY && (k == '0) && (src == SRC_ALU);
    assign GNT_MEM  = BUSY && (k == '0) && (src == SRC_MEM);
    assign DONE     = BUSY && (k == LAST_K);
    assign DONE_SRC = DONE && (src == SRC_MEM);

    // An address past the last register matches no row, so nothing is written.
    always_comb begin
        WE_N = '1;
        WD   = '0;
        for (int r = 0; r < REGS; r++) begin
            for (int e = 0; e < LANES; e++) begin
                WE_N[r*LANES+e] = !(BUSY && (int'(addr) == r) && (int'(k) == e));
            end
        end
        if (BUSY) begin
            for (int e = 0; e < LANES; e++) begin
                if (int'(k) == e) begin
                    WD = data[e*N +: N];
                end
            end
        end
    end

endmodule

// File: tb/tb_vector_writeback_arbiter.sv
// Bench for vector_writeback_arbiter: vector table, directed corner sequences and
// random traffic compared against a transfer-level queue model.
module tb_vector_writeback_arbiter;

    localparam int N     = 8;
    localparam int LANES = 4;
    localparam int REGS  = 8;

    typedef struct packed {
        logic                  gnt_alu;
        logic                  gnt_mem;
        logic                  busy;
        logic                  done;
        logic                  done_src;
        logic [REGS*LANES-1:0] we_n;
        logic [N-1:0]          wd;
    } out_t;

    typedef struct {
        logic        rst;
        logic        ra;
        logic [2:0]  aa;
        logic [31:0] da;
        logic        rm;
        logic [2:0]  am;
        logic [31:0] dm;
        out_t        exp;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        req_alu, req_mem;
    logic [2:0]  addr_alu, addr_mem;
    logic [31:0] data_alu, data_mem;
    logic        gnt_alu, gnt_mem, busy, done, done_src;
    logic [31:0] we_n;
    logic [7:0]  wd;

    logic        r1_req_alu, r1_req_mem;
    logic [2:0]  r1_addr_alu, r1_addr_mem;
    logic [7:0]  r1_data_alu, r1_data_mem;
    logic        o1_gnt_alu, o1_gnt_mem, o1_busy, o1_done, o1_done_src;
    logic [5:0]  o1_we_n;
    logic [7:0]  o1_wd;

    int   checks = 0;
    int   errors = 0;
    out_t mq[$];
    int   m_last = 1;
    logic [7:0] shadow [REGS*LANES];

    vector_writeback_arbiter #(.N(N), .LANES(LANES), .REGS(REGS)) dut (
        .CLK(clk), .RST(rst),
        .REQ_ALU(req_alu), .ADDR_ALU(addr_alu), .DATA_ALU(data_alu),
        .REQ_MEM(req_mem), .ADDR_MEM(addr_mem), .DATA_MEM(data_mem),
        .GNT_ALU(gnt_alu), .GNT_MEM(gnt_mem), .WE_N(we_n), .WD(wd),
        .BUSY(busy), .DONE(done), .DONE_SRC(done_src)
    );

    vector_writeback_arbiter #(.N(8), .LANES(1), .REGS(6)) dut1 (
        .CLK(clk), .RST(rst),
        .REQ_ALU(r1_req_alu), .ADDR_ALU(r1_addr_alu), .DATA_ALU(r1_data_alu),
        .REQ_MEM(r1_req_mem), .ADDR_MEM(r1_addr_mem), .DATA_MEM(r1_data_mem),
        .GNT_ALU(o1_gnt_alu), .GNT_MEM(o1_gnt_mem), .WE_N(o1_we_n), .WD(o1_wd),
        .BUSY(o1_busy), .DONE(o1_done), .DONE_SRC(o1_done_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Element registers as the write path sees them.
    always @(posedge clk) begin
        for (int i = 0; i < REGS*LANES; i++) begin
            if (we_n[i] === 1'b0) shadow[i] <= wd;
        end
    end

    function automatic out_t idle_out();
        out_t o;
        o      = '0;
        o.we_n = '1;
        return o;
    endfunction

    // Reference: an accepted vector is planned as LANES future output cycles.
    always @(posedge clk) begin : model
        out_t        rec;
        int          src;
        int          ai;
        logic [31:0] d;
        bit          was_busy;
        was_busy = (mq.size() != 0);
        if (was_busy) void'(mq.pop_front());
        if (rst) begin
            mq.delete();
            m_last = 1;
        end else if (!was_busy && (req_alu || req_mem)) begin
            if (req_alu && req_mem) src = 1 - m_last;
            else                    src = req_mem ? 1 : 0;
            m_last = src;
            ai = src ? int'(addr_mem) : int'(addr_alu);
            d  = src ? data_mem : data_alu;
            for (int e = 0; e < LANES; e++) begin
                rec          = idle_out();
                rec.gnt_alu  = (e == 0) && (src == 0);
                rec.gnt_mem  = (e == 0) && (src == 1);
                rec.busy     = 1'b1;
                rec.done     = (e == LANES - 1);
                rec.done_src = rec.done && (src == 1);
                if (ai < REGS) rec.we_n[ai*LANES+e] = 1'b0;
                rec.wd       = d[e*N +: N];
                mq.push_back(rec);
            end
        end
    end

    function automatic out_t model_exp();
        if (mq.size() != 0) return mq[0];
        return idle_out();
    endfunction

    function automatic out_t dut_out();
        out_t o;
        o.gnt_alu  = gnt_alu;
        o.gnt_mem  = gnt_mem;
        o.busy     = busy;
        o.done     = done;
        o.done_src = done_src;
        o.we_n     = we_n;
        o.wd       = wd;
        return o;
    endfunction

    function automatic vec_t row(logic r, logic ra, logic [2:0] aa, logic [31:0] da,
                                 logic rm, logic [2:0] am, logic [31:0] dm,
                                 logic [4:0] flags, int we_bit, logic [7:0] wdv);
        vec_t v;
        v.rst = r;  v.ra = ra; v.aa = aa; v.da = da;
        v.rm  = rm; v.am = am; v.dm = dm;
        v.exp          = idle_out();
        v.exp.gnt_alu  = flags[4];
        v.exp.gnt_mem  = flags[3];
        v.exp.busy     = flags[2];
        v.exp.done     = flags[1];
        v.exp.done_src = flags[0];
        if (we_bit >= 0) v.exp.we_n[we_bit] = 1'b0;
        v.exp.wd       = wdv;
        return v;
    endfunction

    task automatic apply_stimulus(input vec_t v);
        rst      = v.rst;
        req_alu  = v.ra;
        addr_alu = v.aa;
        data_alu = v.da;
        req_mem  = v.rm;
        addr_mem = v.am;
        data_mem = v.dm;
    endtask

    task automatic check_output(input string name, input out_t exp);
        out_t got;
        got = dut_out();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        check_output("model", model_exp());
    endtask

    localparam logic [31:0] DA1 = 32'h44332211;
    localparam logic [31:0] DA2 = 32'hA4A3A2A1;
    localparam logic [31:0] DM2 = 32'hB4B3B2B1;

    vec_t        tbl [18];
    int          order [4];
    int          n_gnt;
    logic [7:0]  pre2, pre3;
    logic [31:0] dr;

    initial begin
        tbl[0]  = row(0, 1, 3, DA1, 0, 0, 0,   5'b00000, -1, 8'h00);
        tbl[1]  = row(0, 0, 3, DA1, 0, 0, 0,   5'b10100, 12, 8'h11);
        tbl[2]  = row(0, 0, 3, DA1, 0, 0, 0,   5'b00100, 13, 8'h22);
        tbl[3]  = row(0, 0, 3, DA1, 0, 0, 0,   5'b00100, 14, 8'h33);
        tbl[4]  = row(0, 0, 3, DA1, 0, 0, 0,   5'b00110, 15, 8'h44);
        tbl[5]  = row(0, 0, 0, 0,   0, 0, 0,   5'b00000, -1, 8'h00);
        tbl[6]  = row(1, 0, 0, 0,   0, 0, 0,   5'b00000, -1, 8'h00);
        tbl[7]  = row(0, 1, 1, DA2, 1, 2, DM2, 5'b00000, -1, 8'h00);
        tbl[8]  = row(0, 0, 1, DA2, 1, 2, DM2, 5'b10100,  4, 8'hA1);
        tbl[9]  = row(0, 0, 1, DA2, 1, 2, DM2, 5'b00100,  5, 8'hA2);
        tbl[10] = row(0, 0, 1, DA2, 1, 2, DM2, 5'b00100,  6, 8'hA3);
        tbl[11] = row(0, 0, 1, DA2, 1, 2, DM2, 5'b00110,  7, 8'hA4);
        tbl[12] = row(0, 0, 1, DA2, 1, 2, DM2, 5'b00000, -1, 8'h00);
        tbl[13] = row(0, 0, 0, 0,   0, 2, DM2, 5'b01100,  8, 8'hB1);
        tbl[14] = row(0, 0, 0, 0,   0, 0, 0,   5'b00100,  9, 8'hB2);
        tbl[15] = row(0, 0, 0, 0,   0, 0, 0,   5'b00100, 10, 8'hB3);
        tbl[16] = row(0, 0, 0, 0,   0, 0, 0,   5'b00111, 11, 8'hB4);
        tbl[17] = row(0, 0, 0, 0,   0, 0, 0,   5'b00000, -1, 8'h00);

        rst = 1'b1;
        req_alu = 0; addr_alu = 0; data_alu = 0;
        req_mem = 0; addr_mem = 0; data_mem = 0;
        r1_req_alu = 0; r1_addr_alu = 0; r1_data_alu = 0;
        r1_req_mem = 0; r1_addr_mem = 0; r1_data_mem = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_output("reset_state", idle_out());
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            cycle();
            check_output($sformatf("vec%0d", i), tbl[i].exp);
            apply_stimulus(tbl[i]);
        end

        // MEM request raised while an ALU transfer is running.
        req_alu = 1; addr_alu = 0; data_alu = $urandom;
        cycle();
        check_val("busy_gnt_alu", gnt_alu, 1);
        req_alu = 0;
        cycle();
        check_val("busy_no_gnt_mem_c2", gnt_mem, 0);
        req_mem = 1; addr_mem = 6; data_mem = $urandom;
        for (int c = 3; c <= 5; c++) begin
            cycle();
            check_val($sformatf("busy_no_gnt_mem_c%0d", c), gnt_mem, 0);
        end
        check_val("busy_idle_gap", busy, 0);
        cycle();
        check_val("busy_gnt_mem_c6", gnt_mem, 1);
        req_mem = 0;
        repeat (4) cycle();

        // Rotation with both sources re-requesting continuously.
        rst = 1;
        cycle();
        rst = 0;
        foreach (order[i]) order[i] = 9;
        n_gnt = 0;
        req_alu = 1; addr_alu = 3'($urandom_range(0, 7)); data_alu = $urandom;
        req_mem = 1; addr_mem = 3'($urandom_range(0, 7)); data_mem = $urandom;
        for (int c = 0; c < 40 && n_gnt < 4; c++) begin
            cycle();
            if (gnt_alu && n_gnt < 4) begin order[n_gnt] = 0; n_gnt++; req_alu = 0; end
            else req_alu = 1;
            if (gnt_mem && n_gnt < 4) begin order[n_gnt] = 1; n_gnt++; req_mem = 0; end
            else req_mem = 1;
        end
        req_alu = 0; req_mem = 0;
        check_val("rot_count", n_gnt, 4);
        for (int i = 0; i < 4; i++) check_val($sformatf("rot_order%0d", i), order[i], i % 2);
        repeat (LANES + 1) cycle();

        // Reset in the second write cycle aborts the transfer.
        pre2 = shadow[5*LANES+2];
        pre3 = shadow[5*LANES+3];
        dr = $urandom;
        dr[23:16] = ~pre2;
        dr[31:24] = ~pre3;
        req_alu = 1; addr_alu = 5; data_alu = dr;
        cycle();
        check_val("abort_gnt", gnt_alu, 1);
        req_alu = 0;
        cycle();
        rst = 1;
        cycle();
        check_output("abort_reset_values", idle_out());
        rst = 0;
        repeat (3) cycle();
        check_val("abort_elem0", shadow[5*LANES+0], dr[7:0]);
        check_val("abort_elem1", shadow[5*LANES+1], dr[15:8]);
        check_val("abort_elem2", shadow[5*LANES+2], pre2);
        check_val("abort_elem3", shadow[5*LANES+3], pre3);

        // Random traffic; requesters hold REQ until granted.
        for (int c = 0; c < 400; c++) begin
            cycle();
            if (gnt_alu) req_alu = 0;
            else if (!req_alu && $urandom_range(0, 2) == 0) begin
                req_alu = 1; addr_alu = 3'($urandom_range(0, 7)); data_alu = $urandom;
            end
            if (gnt_mem) req_mem = 0;
            else if (!req_mem && $urandom_range(0, 2) == 0) begin
                req_mem = 1; addr_mem = 3'($urandom_range(0, 7)); data_mem = $urandom;
            end
            rst = ($urandom_range(0, 59) == 0);
        end
        rst = 0; req_alu = 0; req_mem = 0;
        repeat (LANES + 2) cycle();

        // Single-lane instance with an out-of-range address.
        r1_req_alu = 1; r1_addr_alu = 2; r1_data_alu = 8'h5C;
        cycle();
        check_val("l1_gnt_alu", o1_gnt_alu, 1);
        check_val("l1_done_a", o1_done, 1);
        check_val("l1_done_src_a", o1_done_src, 0);
        check_val("l1_we_n_a", o1_we_n, 6'b111011);
        check_val("l1_wd_a", o1_wd, 8'h5C);
        r1_req_alu = 0;
        r1_req_mem = 1; r1_addr_mem = 7; r1_data_mem = 8'h3D;
        cycle();
        check_val("l1_idle_busy", o1_busy, 0);
        check_val("l1_idle_done", o1_done, 0);
        cycle();
        check_val("l1_gnt_mem", o1_gnt_mem, 1);
        check_val("l1_done_m", o1_done, 1);
        check_val("l1_done_src_m", o1_done_src, 1);
        check_val("l1_we_n_m", o1_we_n, 6'b111111);
        check_val("l1_wd_m", o1_wd, 8'h3D);
        r1_req_mem = 0;
        cycle();
        check_val("l1_end_busy", o1_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
